// File: rtl/temporal_encoder.sv
`default_nettype none
// ============================================================================
// temporal_encoder: sliding-window N-gram binder (XOR of rotated spatial HVs)
// Revision: 1.0
// ============================================================================
`ifndef HV_DIMENSION
`define HV_DIMENSION 32
`endif

module temporal_encoder #(
   parameter int NGRAM_SIZE       = 4,
   parameter int NGRAM_SIZE_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      hvin_valid,
   output logic                      hvin_ready,
   input  logic [`HV_DIMENSION-1:0]  hvin,
   output logic                      hvout_valid,
   input  logic                      hvout_ready,
   output logic [`HV_DIMENSION-1:0]  hvout
);

   localparam int D          = `HV_DIMENSION;
   localparam int HIST_DEPTH = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
   localparam logic [NGRAM_SIZE_WIDTH-1:0] FILL_MAX = NGRAM_SIZE_WIDTH'(NGRAM_SIZE - 1);

   logic [D-1:0]                hist_q [HIST_DEPTH];
   logic [NGRAM_SIZE_WIDTH-1:0] fill_q;
   logic [D-1:0]                hvout_q;
   logic                        hvout_valid_q;
   logic [D-1:0]                hvout_d;
   logic                        fire;

   // Rotate left by k: bit i of the result takes bit (i-k) mod D of x.
   function automatic logic [D-1:0] rho(input logic [D-1:0] x, input int k);
      int s;
      s = k % D;
      return (x << s) | (x >> (D - s));
   endfunction

   assign hvin_ready  = !rst && !clear && (!hvout_valid_q || hvout_ready);
   assign fire        = hvin_valid && hvin_ready;
   assign hvout       = hvout_q;
   assign hvout_valid = hvout_valid_q;

   always_comb begin
      hvout_d = hvin;
      for (int k = 1; k < NGRAM_SIZE; k++) begin
         hvout_d = hvout_d ^ rho(hist_q[k-1], k);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
         fill_q        <= '0;
         hvout_q       <= '0;
         hvout_valid_q <= 1'b0;
      end else if (clear) begin
         // New trial: pending output is dropped but its data is left in place.
         for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
         fill_q        <= '0;
         hvout_valid_q <= 1'b0;
      end else if (fire) begin
         hist_q[0] <= hvin;
         for (int k = 1; k < HIST_DEPTH; k++) hist_q[k] <= hist_q[k-1];
         if (fill_q == FILL_MAX) begin
            hvout_q       <= hvout_d;
            hvout_valid_q <= 1'b1;
         end else begin
            fill_q        <= fill_q + NGRAM_SIZE_WIDTH'(1);
            hvout_valid_q <= hvout_valid_q && !hvout_ready;
         end
      end else begin
         hvout_valid_q <= hvout_valid_q && !hvout_ready;
      end
   end

endmodule

`default_nettype wire
